// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its round-robin front end.
// Holds the opcodes, the opcode legality test and the arbiter FSM states.
package alu_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_NOTA = 3'b100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Opcodes 101..111 are reserved and produce an error response.
   function automatic logic isLegalOp(input logic [2:0] op);
      return (op <= OP_NOTA);
   endfunction

endpackage

// File: rtl/alu.sv
// Purely combinational 8-bit ALU: ADD, SUB, AND, OR, NOT A.
// ADD/SUB wrap modulo 2^WIDTH; reserved opcodes yield zero.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [2:0]       i_op,
   output logic [WIDTH-1:0] o_result
);

   always_comb begin
      o_result = '0;
      case (i_op)
         OP_ADD:  o_result = i_a + i_b;
         OP_SUB:  o_result = i_a - i_b;
         OP_AND:  o_result = i_a & i_b;
         OP_OR:   o_result = i_a | i_b;
         OP_NOTA: o_result = ~i_a;
         default: o_result = '0;
      endcase
   end

endmodule

// File: rtl/alu_rr_arbiter_rr_pick.sv
// Combinational round-robin search: first active request strictly after
// the last grant, wrapping around, reported as one-hot and as an index.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_last,
   output logic [N_REQ-1:0] o_grant,
   output logic [IDX_W-1:0] o_index,
   output logic             o_any
);

   logic [IDX_W:0]   w_sum;
   logic [IDX_W-1:0] w_cand;

   // The extra sum bit covers last+k up to 2*N_REQ-1 before the wrap.
   always_comb begin
      o_grant = '0;
      o_index = '0;
      o_any   = 1'b0;
      w_sum   = '0;
      w_cand  = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         w_sum = {1'b0, i_last} + (IDX_W+1)'(k);
         if (w_sum >= (IDX_W+1)'(N_REQ)) begin
            w_sum = w_sum - (IDX_W+1)'(N_REQ);
         end
         w_cand = w_sum[IDX_W-1:0];
         if (!o_any && i_req[w_cand]) begin
            o_any           = 1'b1;
            o_grant[w_cand] = 1'b1;
            o_index         = w_cand;
         end
      end
   end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin front end sharing one ALU among N_REQ requesters with
// valid/ready handshakes; operands and result are registered around the ALU.
module alu_rr_arbiter
   import alu_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   input  logic [N_REQ*3-1:0]     req_op,
   output logic [N_REQ-1:0]       rsp_valid,
   input  logic [N_REQ-1:0]       rsp_ready,
   output logic [WIDTH-1:0]       rsp_result,
   output logic                   rsp_err,
   output logic                   busy
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(N_REQ - 1);

   state_t r_state;
   state_t w_nextState;

   logic [IDX_W-1:0] r_lastGrant;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_result;
   logic             r_err;

   logic [N_REQ-1:0] w_pickGrant;
   logic [IDX_W-1:0] w_pickIdx;
   logic             w_pickAny;
   logic             w_accept;
   logic [WIDTH-1:0] w_aluResult;

   logic [WIDTH-1:0] w_aArr  [N_REQ];
   logic [WIDTH-1:0] w_bArr  [N_REQ];
   logic [2:0]       w_opArr [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign w_aArr[g]  = req_a[g*WIDTH +: WIDTH];
      assign w_bArr[g]  = req_b[g*WIDTH +: WIDTH];
      assign w_opArr[g] = req_op[g*3 +: 3];
   end

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .i_req   (req_valid),
      .i_last  (r_lastGrant),
      .o_grant (w_pickGrant),
      .o_index (w_pickIdx),
      .o_any   (w_pickAny)
   );

   alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .i_a      (r_a),
      .i_b      (r_b),
      .i_op     (r_op),
      .o_result (w_aluResult)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Grants are gated by rst so nothing is accepted during a reset cycle.
   always_comb begin
      w_nextState = r_state;
      req_ready   = '0;
      rsp_valid   = '0;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_pickAny && !rst) begin
               req_ready   = w_pickGrant;
               w_accept    = 1'b1;
               w_nextState = EXEC;
            end
         end
         EXEC: begin
            w_nextState = RESP;
         end
         RESP: begin
            rsp_valid[r_lastGrant] = 1'b1;
            if (rsp_ready[r_lastGrant]) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // The last-grant register doubles as the index of the requester being served.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lastGrant <= LAST_INIT;
         r_a         <= '0;
         r_b         <= '0;
         r_op        <= '0;
         r_result    <= '0;
         r_err       <= 1'b0;
      end else begin
         if (w_accept) begin
            r_lastGrant <= w_pickIdx;
            r_a         <= w_aArr[w_pickIdx];
            r_b         <= w_bArr[w_pickIdx];
            r_op        <= w_opArr[w_pickIdx];
         end
         if (r_state == EXEC) begin
            r_result <= isLegalOp(r_op) ? w_aluResult : '0;
            r_err    <= !isLegalOp(r_op);
         end
      end
   end

   assign rsp_result = r_result;
   assign rsp_err    = r_err;
   assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed and randomized checks of alu_rr_arbiter against a transaction-level
// model of round-robin selection and ALU arithmetic.
module tb_alu_rr_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a;
   logic [N*W-1:0] req_b;
   logic [N*3-1:0] req_op;
   logic [N-1:0]   rsp_valid;
   logic [N-1:0]   rsp_ready;
   logic [W-1:0]   rsp_result;
   logic           rsp_err;
   logic           busy;

   logic [W-1:0] tbA  [N];
   logic [W-1:0] tbB  [N];
   logic [2:0]   tbOp [N];

   int nTests = 0;
   int nFail  = 0;
   int mLast  = N - 1;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign req_a[g*W +: W] = tbA[g];
      assign req_b[g*W +: W] = tbB[g];
      assign req_op[g*3 +: 3] = tbOp[g];
   end

   alu_rr_arbiter #(
      .N_REQ (N),
      .WIDTH (W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   // Reference: first valid requester after the last grant, wrapping.
   function automatic int modelPick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (last + k) % N;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   // Reference result as {err, result}, from plain integer arithmetic.
   function automatic logic [8:0] modelAlu(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
      int ia;
      int ib;
      int r;
      ia = a;
      ib = b;
      r  = 0;
      case (op)
         3'd0:    r = (ia + ib) % 256;
         3'd1:    r = (ia - ib + 256) % 256;
         3'd2:    r = ia & ib;
         3'd3:    r = ia | ib;
         3'd4:    r = 255 - ia;
         default: return 9'h100;
      endcase
      return {1'b0, r[7:0]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nTests++;
      assert (observed === expected) else begin
         nFail++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic doReset();
      rst       = 1'b1;
      req_valid = '0;
      rsp_ready = '1;
      step();
      step();
      rst   = 1'b0;
      mLast = N - 1;
   endtask

   // One full transaction starting in an IDLE cycle with inputs already driven.
   // hold = number of extra RESP cycles with the winner's rsp_ready low.
   task automatic applyStimulus(input string tag, input int hold, input logic [N-1:0] withdraw,
                                output logic [N-1:0] gnt, output logic [W-1:0] res,
                                output logic er);
      int           w;
      logic [8:0]   exp;
      logic [N-1:0] oh;
      #1;
      gnt = req_ready;
      res = '0;
      er  = 1'b0;
      w   = modelPick(req_valid, mLast);
      if (w < 0) begin
         checkOutput({tag, ".idle_ready"}, req_ready, 0);
         return;
      end
      oh    = '0;
      oh[w] = 1'b1;
      exp   = modelAlu(tbOp[w], tbA[w], tbB[w]);
      checkOutput({tag, ".req_ready"}, req_ready, oh);
      checkOutput({tag, ".busy_idle"}, busy, 0);
      step();
      mLast        = w;
      req_valid[w] = 1'b0;
      req_valid    = req_valid & ~withdraw;
      rsp_ready    = (hold == 0) ? '1 : ~oh;
      #1;
      checkOutput({tag, ".exec_rsp_valid"}, rsp_valid, 0);
      checkOutput({tag, ".exec_req_ready"}, req_ready, 0);
      checkOutput({tag, ".exec_busy"}, busy, 1);
      step();
      res = rsp_result;
      er  = rsp_err;
      checkOutput({tag, ".rsp_valid"}, rsp_valid, oh);
      checkOutput({tag, ".rsp_result"}, rsp_result, exp[7:0]);
      checkOutput({tag, ".rsp_err"}, rsp_err, exp[8]);
      for (int h = 0; h < hold; h++) begin
         step();
         checkOutput({tag, ".stall_rsp_valid"}, rsp_valid, oh);
         checkOutput({tag, ".stall_result"}, rsp_result, exp[7:0]);
         checkOutput({tag, ".stall_req_ready"}, req_ready, 0);
         checkOutput({tag, ".stall_busy"}, busy, 1);
      end
      rsp_ready = '1;
      step();
      checkOutput({tag, ".done_rsp_valid"}, rsp_valid, 0);
      checkOutput({tag, ".done_busy"}, busy, 0);
   endtask

   logic [N-1:0] gnt;
   logic [W-1:0] res;
   logic         er;

   initial begin
      logic [7:0] singleExp [5];
      logic [2:0] singleOp  [5];
      singleExp = '{8'd25, 8'd5, 8'd10, 8'd15, 8'd240};
      singleOp  = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
      for (int i = 0; i < N; i++) begin
         tbA[i]  = '0;
         tbB[i]  = '0;
         tbOp[i] = '0;
      end

      // Reset with every requester asking: nothing may be accepted.
      rst       = 1'b1;
      req_valid = '1;
      rsp_ready = '1;
      step();
      step();
      checkOutput("reset.req_ready", req_ready, 0);
      checkOutput("reset.rsp_valid", rsp_valid, 0);
      checkOutput("reset.rsp_result", rsp_result, 0);
      checkOutput("reset.rsp_err", rsp_err, 0);
      checkOutput("reset.busy", busy, 0);
      rst       = 1'b0;
      req_valid = '0;
      mLast     = N - 1;
      step();

      // Single requester, every legal opcode.
      for (int i = 0; i < 5; i++) begin
         tbA[0]    = 8'd15;
         tbB[0]    = 8'd10;
         tbOp[0]   = singleOp[i];
         req_valid = 4'b0001;
         applyStimulus("single", 0, '0, gnt, res, er);
         checkOutput("single.grant", gnt, 4'b0001);
         checkOutput("single.value", res, singleExp[i]);
         checkOutput("single.err", er, 0);
      end

      // Contention from reset: two full rounds in order 0,1,2,3.
      doReset();
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < N; i++) begin
            tbA[i]  = 8'($urandom);
            tbB[i]  = 8'($urandom);
            tbOp[i] = 3'($urandom_range(0, 7));
         end
         req_valid = '1;
         for (int k = 0; k < N; k++) begin
            applyStimulus("contend", 0, '0, gnt, res, er);
            checkOutput("contend.order", gnt, 32'(1) << k);
         end
      end

      // Backpressure on requester 2 while requester 0 waits.
      tbA[1] = 8'd1; tbB[1] = 8'd2; tbOp[1] = 3'b000;
      req_valid = 4'b0010;
      applyStimulus("bp.pre", 0, '0, gnt, res, er);
      tbA[2] = 8'h5a; tbB[2] = 8'h0f; tbOp[2] = 3'b011;
      tbA[0] = 8'h33; tbB[0] = 8'h11; tbOp[0] = 3'b001;
      req_valid = 4'b0101;
      applyStimulus("bp", 5, '0, gnt, res, er);
      checkOutput("bp.grant", gnt, 4'b0100);
      checkOutput("bp.value", res, 8'h5f);
      applyStimulus("bp.next", 0, '0, gnt, res, er);
      checkOutput("bp.next_grant", gnt, 4'b0001);

      // Wraparound arithmetic and an illegal opcode.
      tbA[3] = 8'd200; tbB[3] = 8'd100; tbOp[3] = 3'b000;
      req_valid = 4'b1000;
      applyStimulus("wrap.add", 0, '0, gnt, res, er);
      checkOutput("wrap.add_value", res, 8'd44);
      tbA[3] = 8'd5; tbB[3] = 8'd10; tbOp[3] = 3'b001;
      req_valid = 4'b1000;
      applyStimulus("wrap.sub", 0, '0, gnt, res, er);
      checkOutput("wrap.sub_value", res, 8'd251);
      tbOp[3] = 3'b110;
      req_valid = 4'b1000;
      applyStimulus("illegal", 0, '0, gnt, res, er);
      checkOutput("illegal.value", res, 8'h00);
      checkOutput("illegal.err", er, 1);

      // Reset during EXEC aborts the transaction.
      tbA[1] = 8'd7; tbB[1] = 8'd9; tbOp[1] = 3'b000;
      req_valid = 4'b0010;
      #1;
      checkOutput("rexec.grant", req_ready, 4'b0010);
      step();
      req_valid = '0;
      rst       = 1'b1;
      #1;
      checkOutput("rexec.busy_exec", busy, 1);
      step();
      rst   = 1'b0;
      mLast = N - 1;
      #1;
      checkOutput("rexec.rsp_valid", rsp_valid, 0);
      checkOutput("rexec.busy", busy, 0);
      checkOutput("rexec.rsp_result", rsp_result, 0);
      checkOutput("rexec.rsp_err", rsp_err, 0);
      checkOutput("rexec.req_ready", req_ready, 0);
      for (int c = 0; c < 3; c++) begin
         step();
         checkOutput("rexec.quiet_rsp_valid", rsp_valid, 0);
         checkOutput("rexec.quiet_busy", busy, 0);
      end
      req_valid = '1;
      applyStimulus("rexec.after", 0, '0, gnt, res, er);
      checkOutput("rexec.first_grant", gnt, 4'b0001);
      for (int k = 1; k < N; k++) begin
         applyStimulus("rexec.drain", 0, '0, gnt, res, er);
      end

      // Withdrawal: requester 1 drops its request while requester 3 is served.
      req_valid = 4'b0100;
      applyStimulus("wd.pre", 0, '0, gnt, res, er);
      tbA[3] = 8'hf0; tbB[3] = 8'h0f; tbOp[3] = 3'b010;
      req_valid = 4'b1010;
      applyStimulus("wd", 0, 4'b0010, gnt, res, er);
      checkOutput("wd.grant", gnt, 4'b1000);
      for (int c = 0; c < 6; c++) begin
         step();
         checkOutput("wd.req_ready", req_ready, 0);
         checkOutput("wd.rsp_valid", rsp_valid, 0);
         checkOutput("wd.busy", busy, 0);
      end

      // Randomized masks, operands, opcodes and backpressure.
      for (int it = 0; it < 24; it++) begin
         for (int i = 0; i < N; i++) begin
            tbA[i]  = 8'($urandom);
            tbB[i]  = 8'($urandom);
            tbOp[i] = 3'($urandom_range(0, 7));
         end
         req_valid = 4'($urandom_range(1, 15));
         applyStimulus("rand", int'($urandom_range(0, 2)), '0, gnt, res, er);
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule

// File: doc/alu_rr_arbiter.md
# alu_rr_arbiter

Shares one 8-bit combinational ALU (ADD, SUB, AND, OR, NOT A) among N requesters. Arbitration is round-robin, with a valid/ready handshake on both the request and response sides. The block sits between client engines and the single ALU instance. It registers operands and the result, so the ALU's combinational path never reaches a client.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, operand/result width; fixed to the ALU width

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  request pending, one bit per requester
- req_ready  out  N_REQ  one-hot accept; at most one bit high per cycle
- req_a  in  N_REQ*WIDTH  operand A; requester i uses slice [i*WIDTH +: WIDTH]
- req_b  in  N_REQ*WIDTH  operand B, same slicing
- req_op  in  N_REQ*3  opcode; requester i uses slice [i*3 +: 3]
- rsp_valid  out  N_REQ  one-hot: result available for that requester
- rsp_ready  in  N_REQ  requester accepts its result
- rsp_result  out  WIDTH  result, shared by all requesters; qualified by rsp_valid
- rsp_err  out  1  opcode was illegal (101..111); qualified by rsp_valid
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, pick the winner: the first requester with req_valid high, searching upward from (last_grant+1) mod N_REQ and wrapping.
  - Assert that winner's req_ready combinationally in the same cycle.
  - On the clock edge, latch its a, b, op and index, set last_grant to the winner, and go to EXEC.
- EXEC:
  - Drive the latched operands and opcode into the ALU.
  - Capture the result in the result register. Force the result to 0x00 and set err when op is 101..111.
  - Go to RESP.
- RESP:
  - Hold rsp_valid[grant] high with rsp_result/rsp_err stable until rsp_ready[grant] is high.
  - On the edge where rsp_ready[grant] is high, return to IDLE.
  - rsp_ready bits for non-granted requesters are ignored.
- Arithmetic:
  - ADD and SUB wrap modulo 2^WIDTH; there is no carry or borrow output.
  - AND/OR are bitwise; NOT A is bitwise inversion of A, and B is ignored.
- Requesters must hold req_valid, a, b and op stable until their req_ready is seen. Dropping req_valid before grant is legal and withdraws the request.
- A requester may keep req_valid high while it waits for its own response. It is not re-granted until RESP completes.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_result=0, rsp_err=0, busy=0, state=IDLE, last_grant=N_REQ-1 (so requester 0 wins first).
- Latency from grant cycle (T) to response:
  - EXEC at T+1.
  - rsp_valid first high at T+2.
  - Earliest next grant is the cycle after the response handshake.
- Minimum issue interval is 3 cycles with rsp_ready tied high.
- If rsp_ready is already high when RESP is entered, the handshake completes in that cycle.
- Simultaneous requests: exactly one is granted. The others see req_ready=0 and wait.
- Fairness: under full load, requester i waits at most N_REQ-1 grants.
- Reset asserted in EXEC or RESP aborts the transaction: no response is issued, and the next cycle is IDLE with reset values.
- No request is accepted in the cycle rst is high.

## Structure
- Shared package alu_pkg holds:
  - Opcode constants OP_ADD=3'b000, OP_SUB=3'b001, OP_AND=3'b010, OP_OR=3'b011, OP_NOTA=3'b100.
  - The opcode legality function.
  - The FSM state enum.
- One sub-module, rr_pick: combinational round-robin priority search (inputs: request vector and last_grant; outputs: one-hot grant and index).
- The existing ALU module is instantiated once inside the arbiter, fed from the latched registers.

## Test plan
- Single request: requester 0 sends A=15, B=10 with ADD, then SUB, AND, OR, NOT A, rsp_ready high -> rsp_result=25, 5, 10, 15, 240; rsp_valid[0] each at T+2; rsp_err=0.
- Contention: all 4 requesters assert at once from reset -> grant order 0,1,2,3; a second round after requester 0 re-requests continues 0,1,2,3; every req_ready is one-hot.
- Backpressure: rsp_ready[2] held low for 5 cycles during requester 2's response -> rsp_valid/rsp_result stable, busy=1, no new grant until the handshake.
- Wrap and illegal opcode: A=200, B=100 with ADD -> 44; A=5, B=10 with SUB -> 251; op=3'b110 -> result 0x00, rsp_err=1.
- Reset in EXEC: assert rst for one cycle at T+1 -> no rsp_valid; all outputs return to reset values; the next grant goes to requester 0.
- Withdrawal: requester 1 drops req_valid before being granted while requester 3 is served -> requester 1 is never granted and no spurious response is issued.
